// File: rtl/app_dma_pkg.sv
// Shared definitions for the DDR3 application-side DMA feeders:
// command codes, bus widths and the write-controller state encoding.
package app_dma_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 256;
  localparam int MASK_W = 32;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_BUSY = 2'b10
  } wr_state_e;

endpackage

// File: rtl/app_wr_fifo.sv
// Synchronous first-word-fall-through FIFO: block RAM behind a head register,
// so the oldest word is always on rd_data while count is non-zero.
module app_wr_fifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 512,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              I_sys_clk,
  input  logic              I_Rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] head_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              bypass_s;
  logic              refill_s;

  // Words go straight to the head register when it is (or is becoming) vacant
  always_comb begin
    full_s   = (count_r == CW'(DEPTH));
    empty_s  = (count_r == {CW{1'b0}});
    push_s   = wr_en && !full_s;
    pop_s    = rd_en && !empty_s;
    bypass_s = push_s && (empty_s || (pop_s && (count_r == CW'(1))));
    refill_s = pop_s && (count_r > CW'(1));
  end

  // RAM write port and registered read into the head
  always_ff @(posedge I_sys_clk) begin
    if (push_s && !bypass_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
    if (bypass_s) begin
      head_r <= wr_data;
    end else if (refill_s) begin
      head_r <= mem_r[rd_ptr_r];
    end
  end

  // Pointers and occupancy
  always_ff @(posedge I_sys_clk) begin
    if (!I_Rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s && !bypass_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (refill_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  assign rd_data = head_r;
  assign full    = full_s;
  assign empty   = empty_s;
  assign count   = count_r;

endmodule

// File: rtl/app_wr_ctrl.sv
// Write-side feeder for the DDR3 write DMA: buffers the user stream and
// requests one burst at a wrapping linear address whenever a burst is buffered.
module app_wr_ctrl
  import app_dma_pkg::*;
#(
  parameter int                BURST_LEN  = 64,
  parameter logic [ADDR_W-1:0] ADDR_BASE  = 28'h0000000,
  parameter logic [ADDR_W-1:0] ADDR_END   = 28'h0100000,
  parameter int                FIFO_DEPTH = 512
) (
  input  logic              I_sys_clk,
  input  logic              I_Rst_n,
  input  logic              I_frame_start,
  input  logic              I_wr_valid,
  input  logic [DATA_W-1:0] I_wr_data,
  output logic              O_wr_ready,
  output logic              O_ovf,
  output logic              ex_wr_start,
  output logic [ADDR_W-1:0] ex_wr_addr,
  output logic [2:0]        ex_wr_cmd,
  output logic [7:0]        ex_wr_burst_len,
  output logic [MASK_W-1:0] ex_wr_wdf_mask,
  output logic [DATA_W-1:0] ex_wr_data,
  input  logic              ex_wr_burst_start,
  input  logic              ex_wr_rd_en,
  input  logic              ex_wr_burst_end
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN * 8);

  wr_state_e         state_r;
  wr_state_e         state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic              pend_r;
  logic              pend_nxt_s;
  logic              start_r;
  logic              ovf_r;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_rd_s;
  logic [CNT_W-1:0]  fifo_count_s;

  function automatic logic [ADDR_W-1:0] advance_addr(input logic [ADDR_W-1:0] cur);
    logic [ADDR_W-1:0] nxt;
    nxt = cur + ADDR_STEP;
    if (nxt >= ADDR_END) begin
      return ADDR_BASE;
    end else begin
      return nxt;
    end
  endfunction

  assign fifo_rd_s = ex_wr_rd_en && !fifo_empty_s;

  app_wr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .I_sys_clk (I_sys_clk),
    .I_Rst_n   (I_Rst_n),
    .wr_en     (I_wr_valid),
    .wr_data   (I_wr_data),
    .rd_en     (fifo_rd_s),
    .rd_data   (ex_wr_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Burst sequencing; a frame start seen mid-burst is deferred to burst end
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    pend_nxt_s  = pend_r;
    case (state_r)
      ST_IDLE: begin
        if (I_frame_start) begin
          addr_nxt_s = ADDR_BASE;
        end else begin
          addr_nxt_s = addr_r;
        end
        if (fifo_count_s >= CNT_W'(BURST_LEN)) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        pend_nxt_s = pend_r || I_frame_start;
        if (ex_wr_burst_start) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_BUSY: begin
        if (ex_wr_burst_end) begin
          state_nxt_s = ST_IDLE;
          pend_nxt_s  = 1'b0;
          if (pend_r || I_frame_start) begin
            addr_nxt_s = ADDR_BASE;
          end else begin
            addr_nxt_s = advance_addr(addr_r);
          end
        end else begin
          pend_nxt_s = pend_r || I_frame_start;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, address and request registers
  always_ff @(posedge I_sys_clk) begin
    if (!I_Rst_n) begin
      state_r <= ST_IDLE;
      addr_r  <= ADDR_BASE;
      pend_r  <= 1'b0;
      start_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      pend_r  <= pend_nxt_s;
      start_r <= (state_nxt_s == ST_REQ);
    end
  end

  // Sticky overflow: any offered word refused because the FIFO was full
  always_ff @(posedge I_sys_clk) begin
    if (!I_Rst_n) begin
      ovf_r <= 1'b0;
    end else if (I_wr_valid && fifo_full_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign O_wr_ready      = !fifo_full_s;
  assign O_ovf           = ovf_r;
  assign ex_wr_start     = start_r;
  assign ex_wr_addr      = addr_r;
  assign ex_wr_cmd       = CMD_WR;
  assign ex_wr_burst_len = 8'(BURST_LEN);
  assign ex_wr_wdf_mask  = {MASK_W{1'b0}};

endmodule

// File: tb/tb_app_wr_ctrl.sv
// Scoreboard bench for app_wr_ctrl: queue-based FIFO/address model, a DMA
// model that accepts bursts and pops words, and a negedge monitor.
module tb_app_wr_ctrl;
  import app_dma_pkg::*;

  localparam int          BL    = 64;
  localparam int          DEPTH = 512;
  localparam logic [27:0] BASE  = 28'h0000000;
  localparam logic [27:0] AEND  = 28'h0000600;
  localparam logic [27:0] STEP  = 28'h0000200;

  logic         clk;
  logic         rst_n;
  logic         frame_start;
  logic         wr_valid;
  logic [255:0] wr_data;
  logic         wr_ready;
  logic         ovf;
  logic         start;
  logic [27:0]  addr;
  logic [2:0]   cmd;
  logic [7:0]   blen;
  logic [31:0]  mask;
  logic [255:0] rdata;
  logic         burst_start;
  logic         rd_en;
  logic         burst_end;

  logic [255:0] exp_q[$];
  logic [27:0]  addr_q[$];
  logic [27:0]  addr_m;
  bit           busy_m, acc_m, pend_m, ovf_m;
  bit           started, start_prev, accept_en;
  int           pop_cnt;
  int           n_chk, n_pass;

  app_wr_ctrl #(
    .BURST_LEN (BL),
    .ADDR_BASE (BASE),
    .ADDR_END  (AEND),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .I_sys_clk        (clk),
    .I_Rst_n          (rst_n),
    .I_frame_start    (frame_start),
    .I_wr_valid       (wr_valid),
    .I_wr_data        (wr_data),
    .O_wr_ready       (wr_ready),
    .O_ovf            (ovf),
    .ex_wr_start      (start),
    .ex_wr_addr       (addr),
    .ex_wr_cmd        (cmd),
    .ex_wr_burst_len  (blen),
    .ex_wr_wdf_mask   (mask),
    .ex_wr_data       (rdata),
    .ex_wr_burst_start(burst_start),
    .ex_wr_rd_en      (rd_en),
    .ex_wr_burst_end  (burst_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic flag(input string name, input string detail);
    n_chk++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Reference model: the FIFO is a queue; a request is outstanding from the
  // cycle a full burst is buffered in idle until the DMA reports burst end.
  initial begin : model
    int sz;
    bit go;
    logic [27:0] nxt;
    forever begin
      @(posedge clk);
      started = 1'b1;
      if (!rst_n) begin
        exp_q.delete();
        addr_q.delete();
        busy_m = 1'b0; acc_m = 1'b0; pend_m = 1'b0; ovf_m = 1'b0;
        addr_m = BASE;
      end else begin
        sz = exp_q.size();
        go = !busy_m && (sz >= BL);
        if (rd_en && sz > 0) void'(exp_q.pop_front());
        if (wr_valid) begin
          if (sz < DEPTH) exp_q.push_back(wr_data);
          else ovf_m = 1'b1;
        end
        if (busy_m && burst_start) acc_m = 1'b1;
        if (busy_m && burst_end) begin
          nxt = addr_m + STEP;
          addr_m = (pend_m || frame_start || nxt >= AEND) ? BASE : nxt;
          pend_m = 1'b0; busy_m = 1'b0; acc_m = 1'b0;
        end else if (busy_m && frame_start) begin
          pend_m = 1'b1;
        end else if (!busy_m && frame_start) begin
          addr_m = BASE;
        end
        if (go) begin
          busy_m = 1'b1;
          addr_q.push_back(addr_m);
        end
      end
    end
  end

  // DMA model: accept a request, pop BL words with random gaps, then end
  initial begin : dma
    int dst, rem;
    dst = 0; rem = 0;
    burst_start = 1'b0; rd_en = 1'b0; burst_end = 1'b0;
    forever begin
      @(posedge clk); #1;
      burst_start = 1'b0; rd_en = 1'b0; burst_end = 1'b0;
      if (!rst_n) dst = 0;
      else begin
        case (dst)
          0: if (start && accept_en) begin burst_start = 1'b1; rem = BL; dst = 1; end
          1: if ($urandom_range(0, 3) != 0) begin
               rd_en = 1'b1; rem--;
               if (rem == 0) dst = 2;
             end
          default: begin burst_end = 1'b1; dst = 0; end
        endcase
      end
    end
  end

  // Monitor: per-cycle output checks and scoreboard pops
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (started) begin
        chk("wr_ready", wr_ready, exp_q.size() < DEPTH);
        chk("ovf", ovf, ovf_m);
        chk("start", start, busy_m && !acc_m);
        chk("addr", addr, addr_m);
        if (start && !start_prev) begin
          if (addr_q.size() == 0) flag("req_addr", "request seen, none expected");
          else chk("req_addr", addr, addr_q.pop_front());
        end
        if (rd_en) begin
          pop_cnt++;
          if (exp_q.size() == 0) flag("rd_data", "pop seen, model FIFO empty");
          else chk("rd_data", rdata, exp_q[0]);
        end
        start_prev = start;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      for (int k = 0; k < 8; k++) wr_data[k*32 +: 32] = $urandom();
      cyc(1);
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (!busy_m && exp_q.size() < BL) break;
      cyc(1);
    end
    if (busy_m || exp_q.size() >= BL) flag(name, "burst did not complete within 3000 cycles");
  endtask

  task automatic check_addr_at_negedge(input string name, input logic [27:0] exp);
    @(negedge clk);
    chk(name, addr, exp);
    cyc(1);
  endtask

  task automatic push_and_check_start(input string name, input int n, input logic [27:0] exp_addr);
    push_n(n);
    @(negedge clk); chk({name, "_n1_start"}, start, 1'b0);
    cyc(1);
    @(negedge clk); chk({name, "_n2_start"}, start, 1'b1);
    chk({name, "_n2_addr"}, addr, exp_addr);
    cyc(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int base_pops;
    rst_n = 1'b0; frame_start = 1'b0; wr_valid = 1'b0; wr_data = '0; accept_en = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_start", start, 1'b0);
    chk("rst_addr", addr, BASE);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_ready", wr_ready, 1'b1);
    chk("cmd", cmd, CMD_WR);
    chk("burst_len", blen, 8'd64);
    chk("mask", mask, 32'h0);
    cyc(1);

    // single burst, then partial fill, then wrap
    push_and_check_start("single", BL, 28'h000);
    wait_done("single_done");
    check_addr_at_negedge("single_next_addr", 28'h200);

    push_n(BL - 1);
    cyc(20);
    @(negedge clk); chk("partial_no_start", start, 1'b0);
    cyc(1);
    push_and_check_start("partial", 1, 28'h200);
    wait_done("partial_done");
    check_addr_at_negedge("partial_next_addr", 28'h400);

    push_n(BL);
    wait_done("wrap_done");
    check_addr_at_negedge("wrap_addr", 28'h000);

    // frame start while idle, then while busy at 0x200
    push_n(BL);
    wait_done("b4_done");
    frame_start = 1'b1; cyc(1); frame_start = 1'b0;
    check_addr_at_negedge("frame_idle_addr", 28'h000);
    push_n(BL);
    wait_done("b5_done");
    push_n(BL);
    for (int i = 0; i < 200 && !acc_m; i++) cyc(1);
    if (!acc_m) flag("frame_busy_accept", "burst not accepted within 200 cycles");
    frame_start = 1'b1; cyc(1); frame_start = 1'b0;
    wait_done("frame_busy_done");
    check_addr_at_negedge("frame_busy_addr", 28'h000);

    // random traffic with occasional frame starts
    for (int i = 0; i < 800; i++) begin
      wr_valid = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < 8; k++) wr_data[k*32 +: 32] = $urandom();
      frame_start = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    wr_valid = 1'b0; frame_start = 1'b0;
    wait_done("random_done");

    // overflow with a DMA that never accepts
    do_reset();
    accept_en = 1'b0;
    push_n(DEPTH + 1);
    @(negedge clk);
    chk("ovf_ready", wr_ready, 1'b0);
    chk("ovf_flag", ovf, 1'b1);
    cyc(5);
    @(negedge clk); chk("ovf_sticky", ovf, 1'b1);
    cyc(1);
    do_reset();
    accept_en = 1'b1;
    @(negedge clk);
    chk("ovf_rst_flag", ovf, 1'b0);
    chk("ovf_rst_ready", wr_ready, 1'b1);
    chk("ovf_rst_start", start, 1'b0);
    cyc(1);

    // reset after ten pops of a burst, then a clean burst
    push_n(BL);
    base_pops = pop_cnt;
    for (int i = 0; i < 500 && (pop_cnt - base_pops) < 10; i++) cyc(1);
    if ((pop_cnt - base_pops) < 10) flag("midrst_pops", "ten pops not seen within 500 cycles");
    do_reset();
    @(negedge clk);
    chk("midrst_start", start, 1'b0);
    chk("midrst_addr", addr, 28'h000);
    chk("midrst_ready", wr_ready, 1'b1);
    cyc(1);
    push_n(BL);
    wait_done("post_rst_done");
    check_addr_at_negedge("post_rst_addr", 28'h200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
